// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller between the 6502 bus master and the bus fabric.
// Passes CPU cycles through in IDLE; a write to the DMA register halts
// the CPU and copies one page to the OAM data port.
// Ports: clk, rst_n, cpu_addr/cpu_data_out/cpu_wen in,
//   cpu_data_in/cpu_rdy/dma_busy out, mem_addr/mem_data_out/mem_wen out,
//   mem_data_in in.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_wen,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_rdy,
  output logic        dma_busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_wen,
  input  logic [7:0]  mem_data_in
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state;
  state_t     state_nxt;
  logic       parity;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] byte_q;
  logic       trig;

  assign trig        = cpu_wen && (cpu_addr == DMA_REG_ADDR);
  assign cpu_data_in = mem_data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      parity <= 1'b0;
      page   <= 8'h00;
      idx    <= 8'h00;
      byte_q <= 8'h00;
    end else begin
      state  <= state_nxt;
      parity <= ~parity;
      unique case (state)
        IDLE: begin
          if (trig) begin
            page <= cpu_data_out;
            idx  <= 8'h00;
          end
        end
        READ:  byte_q <= mem_data_in;
        WRITE: begin
          if (idx != LAST_IDX) begin
            idx <= idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    cpu_rdy      = 1'b0;
    dma_busy     = 1'b1;
    mem_addr     = cpu_addr;
    mem_data_out = cpu_data_out;
    mem_wen      = 1'b0;
    unique case (state)
      IDLE: begin
        cpu_rdy  = 1'b1;
        dma_busy = 1'b0;
        // The trigger write is consumed here, never forwarded.
        mem_wen  = cpu_wen && !trig;
        if (trig) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        // Reads must land on even cycles; pad one cycle if needed.
        state_nxt = parity ? READ : ALIGN;
      end
      ALIGN: begin
        state_nxt = READ;
      end
      READ: begin
        mem_addr  = {page, idx};
        state_nxt = WRITE;
      end
      WRITE: begin
        mem_addr     = OAM_DATA_ADDR;
        mem_data_out = byte_q;
        mem_wen      = 1'b1;
        state_nxt    = (idx == LAST_IDX) ? IDLE : READ;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: idle vector table, random idle
// traffic, and sprite DMA sequences checked against a transfer model.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_wen;
  logic [7:0]  cpu_data_in;
  logic        cpu_rdy;
  logic        dma_busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic        mem_wen;
  logic [7:0]  mem_data_in;

  always #5 clk = ~clk;

  oam_dma_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_wen      (cpu_wen),
    .cpu_data_in  (cpu_data_in),
    .cpu_rdy      (cpu_rdy),
    .dma_busy     (dma_busy),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_wen      (mem_wen),
    .mem_data_in  (mem_data_in)
  );

  logic [7:0] fab [65536];
  logic [7:0] ref_mem [65536];

  assign mem_data_in = fab[mem_addr];

  always @(posedge clk) begin
    if (mem_wen) fab[mem_addr] <= mem_data_out;
  end

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int oam_wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_wen && mem_addr == 16'h2004) oam_wr_cnt <= oam_wr_cnt + 1;
  end

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    logic        par;
  } rec_t;

  rec_t trace[$];
  bit   rec_en = 1'b0;

  always @(negedge clk) begin
    if (rec_en && (!cpu_rdy || dma_busy))
      trace.push_back('{a: mem_addr, w: mem_wen, d: mem_data_out, par: cyc[0]});
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    cpu_addr     = 16'h1234;
    cpu_data_out = 8'h00;
    cpu_wen      = 1'b0;
  endtask

  task automatic run_dma(input logic [7:0] pg, input int want,
                         input bit noise, input bit pg_ff);
    logic [7:0] exp_d [256];
    int c, align, exp_len, base, ae, de, pe, z, w0;
    bit done;
    for (int i = 0; i < 256; i++) exp_d[i] = ref_mem[{pg, 8'(i)}];
    w0 = oam_wr_cnt;
    @(posedge clk); #2;
    if (cyc[0] != want[0]) begin
      @(posedge clk); #2;
    end
    trace.delete();
    rec_en       = 1'b1;
    cpu_addr     = 16'h4014;
    cpu_data_out = pg;
    cpu_wen      = 1'b1;
    @(negedge clk);
    chk("trig_not_fwd", mem_wen, 0);
    chk("trig_rdy", cpu_rdy, 1);
    c = cyc;
    // HALT parity is (c+1)%2; an even HALT needs the pad cycle.
    align   = (c % 2 == 1) ? 1 : 0;
    exp_len = 1 + align + 2 * 256;
    done    = 1'b0;
    for (int t = 1; t <= exp_len + 40 && !done; t++) begin
      @(posedge clk); #2;
      if (noise && t <= exp_len) begin
        cpu_addr     = ($urandom_range(0, 1) == 1) ? 16'h4014 : 16'($urandom);
        cpu_data_out = 8'($urandom);
        cpu_wen      = 1'($urandom);
      end else begin
        drive_idle();
      end
      @(negedge clk);
      if (cpu_rdy) done = 1'b1;
    end
    rec_en = 1'b0;
    chk("dma_done", 32'(done), 1);
    chk("stall_len", trace.size(), exp_len);
    chk("busy_end", dma_busy, 0);
    ae = 0; de = 0; pe = 0; z = 0;
    for (int i = 0; i < 1 + align && i < trace.size(); i++)
      if (trace[i].w) ae++;
    base = 1 + align;
    for (int i = 0; i < 256; i++) begin
      if (base + 2 * i + 1 < trace.size()) begin
        if (trace[base + 2 * i].a != {pg, 8'(i)} || trace[base + 2 * i].w) ae++;
        if (trace[base + 2 * i].par != 1'b0) pe++;
        if (trace[base + 2 * i + 1].a != 16'h2004 || !trace[base + 2 * i + 1].w) ae++;
        if (trace[base + 2 * i + 1].d != exp_d[i]) de++;
      end else begin
        ae++;
      end
    end
    chk("seq_addr_errs", ae, 0);
    chk("seq_data_errs", de, 0);
    chk("read_parity_errs", pe, 0);
    chk("oam_writes", oam_wr_cnt - w0, 256);
    chk("reg_untouched", fab[16'h4014], 8'hC3);
    if (pg_ff) begin
      foreach (trace[i]) if (trace[i].a == 16'h0000) z++;
      chk("no_page0_access", z, 0);
      if (trace.size() >= 2)
        chk("last_read_ffff", trace[trace.size() - 2].a, 16'hFFFF);
      else
        chk("last_read_ffff", 32'hDEAD, 16'hFFFF);
    end
    ref_mem[16'h2004] = exp_d[255];
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic        ew;
    logic        cr;
    logic [7:0]  er;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, wc;
    bit hit;
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;

    for (int i = 0; i < 65536; i++) begin
      d = 8'($urandom);
      if (i == 16'h4014) d = 8'hC3;
      fab[i]     <= d;
      ref_mem[i]  = d;
    end

    tbl[0] = '{16'h0123, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{16'h0123, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[2] = '{16'h4014, 8'h77, 1'b0, 1'b0, 1'b1, 8'hC3};
    tbl[3] = '{16'h7FFF, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[4] = '{16'h7FFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C};
    tbl[5] = '{16'h0123, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A};

    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("rst_rdy", cpu_rdy, 1);
    chk("rst_busy", dma_busy, 0);
    chk("rst_addr", mem_addr, 16'h1234);
    chk("rst_wen", mem_wen, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk); #2;
      cpu_addr     = tbl[i].a;
      cpu_data_out = tbl[i].d;
      cpu_wen      = tbl[i].w;
      @(negedge clk);
      chk("tbl_addr", mem_addr, tbl[i].a);
      chk("tbl_wen", mem_wen, tbl[i].ew);
      chk("tbl_rdy", cpu_rdy, 1);
      if (tbl[i].w) chk("tbl_wdata", mem_data_out, tbl[i].d);
      if (tbl[i].cr) chk("tbl_rdata", cpu_data_in, tbl[i].er);
      if (tbl[i].w) ref_mem[tbl[i].a] = tbl[i].d;
    end

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      w = 1'($urandom);
      d = 8'($urandom);
      if (a == 16'h4014 || a == 16'h2004) a = 16'h0100;
      @(posedge clk); #2;
      cpu_addr     = a;
      cpu_data_out = d;
      cpu_wen      = w;
      @(negedge clk);
      chk("rnd_wen", mem_wen, w);
      if (!w) chk("rnd_rdata", cpu_data_in, ref_mem[a]);
      if (w) ref_mem[a] = d;
    end

    run_dma(8'h02, 0, 1'b0, 1'b0);
    run_dma(8'h02, 1, 1'b0, 1'b0);
    run_dma(8'hFF, int'($urandom_range(0, 1)), 1'b0, 1'b1);
    run_dma(8'h02, int'($urandom_range(0, 1)), 1'b1, 1'b0);

    for (int k = 0; k < 2; k++) begin
      d = 8'($urandom);
      if (d == 8'h20) d = 8'h21;
      run_dma(d, int'($urandom_range(0, 1)), 1'($urandom), 1'b0);
    end

    w0 = oam_wr_cnt;
    wc = 0;
    hit = 1'b0;
    @(posedge clk); #2;
    cpu_addr     = 16'h4014;
    cpu_data_out = 8'h05;
    cpu_wen      = 1'b1;
    for (int t = 0; t < 400 && !hit; t++) begin
      @(posedge clk); #2;
      drive_idle();
      @(negedge clk);
      if (mem_wen && mem_addr == 16'h2004) wc++;
      if (wc == 100) hit = 1'b1;
    end
    chk("abort_reach_100", 32'(hit), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_rdy", cpu_rdy, 1);
    chk("abort_busy", dma_busy, 0);
    chk("abort_wr_cnt", oam_wr_cnt - w0, 100);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    w0 = oam_wr_cnt;
    repeat (20) @(negedge clk);
    chk("post_abort_no_wr", oam_wr_cnt - w0, 0);
    chk("post_abort_busy", dma_busy, 0);
    run_dma(8'h07, int'($urandom_range(0, 1)), 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom);
      if (a == 16'h4014 || a == 16'h2004) a = 16'h0100;
      @(posedge clk); #2;
      cpu_addr = a;
      cpu_wen  = 1'b0;
      @(negedge clk);
      chk("final_rdata", cpu_data_in, ref_mem[a]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
